circ_queue_ctrl: RTL and testbench

//  Head/tail pointer controller for a LENGTH-entry circular queue (store/load queue, ROB-style buffers).

---
 rtl/cq_pkg.sv | 24 ++
 rtl/cq_range_mask.sv | 26 ++
 rtl/circ_queue_ctrl.sv | 151 +++++++++++++++
 tb/tb_circ_queue_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cq_pkg.sv
// Shared types and pointer arithmetic for the circular queue controller.
// Pointers are {wrap, index}; occupancy is their difference modulo 2*LENGTH.
package cq_pkg;

  localparam int CQ_LENGTH = 16;
  localparam int CQ_PTR_W  = $clog2(CQ_LENGTH) + 1;

  typedef logic [CQ_PTR_W-1:0] CQPtr_t;

  typedef enum logic {
    RUN      = 1'b0,
    COOLDOWN = 1'b1
  } CQState_t;

  // Width-agnostic so any LENGTH override can share it; callers truncate to their pointer width.
  function automatic logic [31:0] cq_occupancy(input logic [31:0] head,
                                               input logic [31:0] tail,
                                               input int unsigned ptr_w);
    logic [31:0] msk;
    msk = (32'd1 << ptr_w) - 32'd1;
    return (tail - head) & msk;
  endfunction

endpackage

// File: rtl/cq_range_mask.sv
// Combinational circular [start, end) entry mask; all ones when the full flag is set.
// Zero latency, no backpressure; start == end without full yields an empty mask.
module cq_range_mask #(
  parameter int LENGTH = 16
) (
  input  logic [$clog2(LENGTH)-1:0] start_idx,
  input  logic [$clog2(LENGTH)-1:0] end_idx,
  input  logic                      full,
  output logic [LENGTH-1:0]         mask
);

  localparam int IDX_W = $clog2(LENGTH);

  always_comb begin
    mask = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (full)
        mask[i] = 1'b1;
      else if (start_idx <= end_idx)
        mask[i] = (IDX_W'(i) >= start_idx) && (IDX_W'(i) < end_idx);
      else
        mask[i] = (IDX_W'(i) >= start_idx) || (IDX_W'(i) < end_idx);
    end
  end

endmodule

// File: rtl/circ_queue_ctrl.sv
// Head/tail controller for a circular queue with flush restore and post-flush allocation cooldown.
// One-cycle latency on all outputs except OUT_allocStall (combinational refusal); CQ_OCCUPANCY_STATS_EN adds stats counters.
module circ_queue_ctrl
  import cq_pkg::*;
#(
  parameter int LENGTH       = 16,
  parameter int ALLOC_W      = 4,
  parameter int COMMIT_W     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(ALLOC_W+1)-1:0]    IN_allocCnt,
  output logic                            OUT_allocStall,
  input  logic [$clog2(COMMIT_W+1)-1:0]   IN_commitCnt,
  input  logic                            IN_flush,
  input  logic [$clog2(LENGTH):0]         IN_flushTail,
  output logic [$clog2(LENGTH):0]         OUT_head,
  output logic [$clog2(LENGTH):0]         OUT_tail,
  output logic [$clog2(LENGTH):0]         OUT_freeCnt,
  output logic [LENGTH-1:0]               OUT_validMask,
  output logic                            OUT_commitErr
`ifdef CQ_OCCUPANCY_STATS_EN
  ,
  output logic [31:0]                     OUT_fullCycles,
  output logic [31:0]                     OUT_stallCycles
`endif
);

  localparam int unsigned IDX_W = $clog2(LENGTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CW    = $clog2(FLUSH_CYCLES + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t     head_q, tail_q, head_d, tail_d;
  ptr_t     occ, occ_d, free_now, free_d;
  ptr_t     alloc_ext, commit_ext, commit_amt;
  ptr_t     dist_flush, dist_tail;
  CQState_t state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic     alloc_en, commit_err_d, flush_ok, full_d;
  logic [LENGTH-1:0] mask_d;

  assign occ        = PTR_W'(cq_occupancy(32'(head_q), 32'(tail_q), PTR_W));
  assign free_now   = PTR_W'(LENGTH) - occ;
  assign alloc_ext  = PTR_W'(IN_allocCnt);
  assign commit_ext = PTR_W'(IN_commitCnt);

  // Commit is clamped to occupancy so head can never overtake tail.
  assign commit_err_d = commit_ext > occ;
  assign commit_amt   = commit_err_d ? occ : commit_ext;
  assign head_d       = head_q + commit_amt;

  // Flush target must sit between the post-commit head and the current tail.
  assign dist_flush = IN_flushTail - head_d;
  assign dist_tail  = tail_q - head_d;
  assign flush_ok   = dist_flush <= dist_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    if (IN_flush) begin
      state_d = COOLDOWN;
      cool_d  = CW'(FLUSH_CYCLES);
    end else if (state_q == COOLDOWN) begin
      cool_d = cool_q - CW'(1);
      if (cool_q <= CW'(1))
        state_d = RUN;
    end
  end

  always_comb begin
    OUT_allocStall = 1'b0;
    alloc_en       = 1'b0;
    case (state_q)
      RUN: begin
        if (IN_flush)
          OUT_allocStall = (IN_allocCnt != '0);
        else if (alloc_ext <= free_now)
          alloc_en = 1'b1;
        else
          OUT_allocStall = 1'b1;
      end
      default: OUT_allocStall = (IN_allocCnt != '0);
    endcase
  end

  always_comb begin
    tail_d = tail_q;
    if (IN_flush)
      tail_d = flush_ok ? IN_flushTail : head_d;
    else if (alloc_en)
      tail_d = tail_q + alloc_ext;
  end

  assign occ_d  = PTR_W'(cq_occupancy(32'(head_d), 32'(tail_d), PTR_W));
  assign full_d = occ_d == PTR_W'(LENGTH);
  assign free_d = PTR_W'(LENGTH) - occ_d;

  cq_range_mask #(.LENGTH(LENGTH)) u_range_mask (
    .start_idx (head_d[IDX_W-1:0]),
    .end_idx   (tail_d[IDX_W-1:0]),
    .full      (full_d),
    .mask      (mask_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      OUT_freeCnt   <= PTR_W'(LENGTH);
      OUT_validMask <= '0;
      OUT_commitErr <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      OUT_freeCnt   <= free_d;
      OUT_validMask <= mask_d;
      OUT_commitErr <= commit_err_d;
    end
  end

  assign OUT_head = head_q;
  assign OUT_tail = tail_q;

`ifdef CQ_OCCUPANCY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_fullCycles  <= '0;
      OUT_stallCycles <= '0;
    end else begin
      if ((occ == PTR_W'(LENGTH)) && !(&OUT_fullCycles))
        OUT_fullCycles <= OUT_fullCycles + 32'd1;
      if (OUT_allocStall && !(&OUT_stallCycles))
        OUT_stallCycles <= OUT_stallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_circ_queue_ctrl.sv
// Directed scoreboard bench for circ_queue_ctrl: stimulus pushes expectations, a negedge monitor retires them.
module tb_circ_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  alloc_cnt = '0;
  logic        alloc_stall;
  logic [2:0]  commit_cnt = '0;
  logic        flush = 1'b0;
  logic [4:0]  flush_tail = '0;
  logic [4:0]  head, tail, free_cnt;
  logic [15:0] valid_mask;
  logic        commit_err;
`ifdef CQ_OCCUPANCY_STATS_EN
  logic [31:0] full_cycles, stall_cycles;
`endif

  always #5 clk = ~clk;

  circ_queue_ctrl #(.LENGTH(16), .ALLOC_W(4), .COMMIT_W(4), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_allocCnt    (alloc_cnt),
    .OUT_allocStall (alloc_stall),
    .IN_commitCnt   (commit_cnt),
    .IN_flush       (flush),
    .IN_flushTail   (flush_tail),
    .OUT_head       (head),
    .OUT_tail       (tail),
    .OUT_freeCnt    (free_cnt),
    .OUT_validMask  (valid_mask),
    .OUT_commitErr  (commit_err)
`ifdef CQ_OCCUPANCY_STATS_EN
    ,
    .OUT_fullCycles (full_cycles),
    .OUT_stallCycles(stall_cycles)
`endif
  );

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  kind;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [4:0]  free;
    logic [15:0] mask;
    logic        err;
    logic        stall;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] c,
                       input logic f, input logic [4:0] ft);
    @(posedge clk);
    #1;
    rst = r; alloc_cnt = a; commit_cnt = c; flush = f; flush_tail = ft;
  endtask

  task automatic exp_state(input logic [4:0] h, input logic [4:0] t, input logic [4:0] fr,
                           input logic [15:0] m, input logic e, input string n);
    exp_t x;
    x = '0;
    x.due = 32'(cyc + 1); x.kind = 2'd0;
    x.head = h; x.tail = t; x.free = fr; x.mask = m; x.err = e;
    exp_q.push_back(x); nm_q.push_back(n);
  endtask

  task automatic exp_stall(input logic s, input string n);
    exp_t x;
    x = '0;
    x.due = 32'(cyc); x.kind = 2'd1; x.stall = s;
    exp_q.push_back(x); nm_q.push_back(n);
  endtask

  task automatic exp_stats(input string n);
    exp_t x;
    x = '0;
    x.due = 32'(cyc + 1); x.kind = 2'd2;
    exp_q.push_back(x); nm_q.push_back(n);
  endtask

  task automatic check(input exp_t x, input string n);
    case (x.kind)
      2'd0: begin
        n_checks++;
        if ({head, tail, free_cnt, valid_mask, commit_err} !== {x.head, x.tail, x.free, x.mask, x.err}) begin
          n_fail++;
          $display("FAIL %s: got head=%0d tail=%0d free=%0d mask=%h err=%b, want head=%0d tail=%0d free=%0d mask=%h err=%b",
                   n, head, tail, free_cnt, valid_mask, commit_err, x.head, x.tail, x.free, x.mask, x.err);
        end
      end
      2'd1: begin
        n_checks++;
        if (alloc_stall !== x.stall) begin
          n_fail++;
          $display("FAIL %s: got stall=%b, want stall=%b", n, alloc_stall, x.stall);
        end
      end
      default: begin
`ifdef CQ_OCCUPANCY_STATS_EN
        n_checks++;
        if (full_cycles !== 32'd0 || stall_cycles !== 32'd0) begin
          n_fail++;
          $display("FAIL %s: got full=%0d stall=%0d, want 0 and 0", n, full_cycles, stall_cycles);
        end
`endif
      end
    endcase
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due == 32'(cyc)) begin
        check(exp_q[i], nm_q[i]);
        exp_q.delete(i);
        nm_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    // Reset and fill to full: tail wraps to {1,0}
    drive(1, 0, 0, 0, 0); exp_state(0, 0, 16, 16'h0000, 0, "reset");
    drive(0, 4, 0, 0, 0); exp_stall(0, "alloc_ok"); exp_state(0, 4, 12, 16'h000F, 0, "alloc1");
    drive(0, 4, 0, 0, 0); exp_state(0, 8, 8, 16'h00FF, 0, "alloc2");
    drive(0, 4, 0, 0, 0); exp_state(0, 12, 4, 16'h0FFF, 0, "alloc3");
    drive(0, 4, 0, 0, 0); exp_state(0, 16, 0, 16'hFFFF, 0, "full_wrap");
    drive(0, 1, 0, 0, 0); exp_stall(1, "stall_full"); exp_state(0, 16, 0, 16'hFFFF, 0, "tail_hold");

    // Walk both pointers round to {1,14}
    drive(0, 0, 4, 0, 0);
    drive(0, 4, 4, 0, 0);
    drive(0, 4, 4, 0, 0);
    drive(0, 4, 4, 0, 0);
    drive(0, 2, 4, 0, 0);
    drive(0, 0, 4, 0, 0);
    drive(0, 0, 4, 0, 0);
    drive(0, 0, 2, 0, 0); exp_state(30, 30, 16, 16'h0000, 0, "empty_wrap");

    drive(0, 4, 0, 0, 0); exp_state(30, 2, 12, 16'hC003, 0, "wrap_alloc");
    drive(0, 0, 2, 0, 0); exp_state(0, 2, 14, 16'h0003, 0, "wrap_commit");

    // Flush with concurrent alloc, then cooldown
    drive(0, 4, 0, 0, 0);
    drive(0, 4, 0, 0, 0); exp_state(0, 10, 6, 16'h03FF, 0, "pre_flush");
    drive(0, 3, 0, 1, 6); exp_state(0, 6, 10, 16'h003F, 0, "flush_valid");
    drive(0, 1, 0, 0, 0); exp_stall(1, "cool1"); exp_state(0, 6, 10, 16'h003F, 0, "cool1_hold");
    drive(0, 1, 0, 0, 0); exp_stall(1, "cool2"); exp_state(0, 6, 10, 16'h003F, 0, "cool2_hold");
    drive(0, 1, 0, 0, 0); exp_stall(0, "run_resume"); exp_state(0, 7, 9, 16'h007F, 0, "run_alloc");

    // Over-commit raises a one-cycle error pulse
    drive(0, 0, 0, 1, 5); exp_state(0, 5, 11, 16'h001F, 0, "flush_shrink");
    drive(0, 0, 7, 0, 0); exp_state(5, 5, 16, 16'h0000, 1, "commit_over");
    drive(0, 0, 0, 0, 0); exp_state(5, 5, 16, 16'h0000, 0, "err_pulse_end");

    // Commit plus out-of-range flush empties the queue
    drive(0, 4, 0, 0, 0); exp_state(5, 9, 12, 16'h01E0, 0, "alloc_after_cool");
    drive(0, 2, 0, 0, 0); exp_state(5, 11, 10, 16'h07E0, 0, "alloc_pre_oob");
    drive(0, 0, 2, 1, 4); exp_state(7, 7, 16, 16'h0000, 0, "flush_oob");

    // Reset while cooling down
    drive(1, 4, 0, 0, 0); exp_state(0, 0, 16, 16'h0000, 0, "rst_in_cool"); exp_stats("stats_clear");
    drive(0, 4, 0, 0, 0); exp_stall(0, "post_rst_run"); exp_state(0, 4, 12, 16'h000F, 0, "post_rst_alloc");
    drive(0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail += exp_q.size();
      $display("FAIL drain_timeout: got %0d pending checks, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
